pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core. Drives stall enables and flush strobes for PC, IFID, IDEX and EXMEM.
//  Detects load-use hazards between ID and the IDEX stage, and squashes wrong-path instructions after EX redirects (br/jal/jalr).
//  Freezes the whole pipe while data memory is busy. Keeps saturating stall and flush statistics counters.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles ifid_flush is held after an accepted redirect (1..15); covers fetch latency
//  CNT_W         16  width of stall_cnt / flush_cnt
// PORTS
//  CLK            in   1      clock, all state on posedge
//  RST            in   1      reset, synchronous, active-low
//  id_rs1         in   5      rs1 address of instruction in ID
//  id_rs2         in   5      rs2 address of instruction in ID
//  id_use_rs1     in   1      ID instruction reads rs1
//  id_use_rs2     in   1      ID instruction reads rs2
//  ex_mem_to_reg  in   1      IDEX mem_to_reg_out (instruction in EX is a load)
//  ex_WRegEn      in   1      IDEX WRegEn_out
//  ex_WReg1       in   5      IDEX WReg1_out
//  ex_redirect    in   1      EX resolved a taken branch, jal or jalr this cycle
//  mem_busy       in   1      data memory not ready; pipeline must hold
//  clr_cnt        in   1      synchronous clear of both statistics counters
//  pc_en          out  1      PC update enable
//  ifid_en        out  1      IFID load enable
//  idex_en        out  1      IDEX load enable
//  exmem_en       out  1      EXMEM load enable
//  ifid_flush     out  1      IFID loads a bubble
//  idex_flush     out  1      IDEX loads a bubble (all control bits 0)
//  state_out      out  2      0=RUN, 1=FLUSH, 2=MWAIT
//  stall_cnt      out  CNT_W  cycles with pc_en=0 outside reset, saturating
//  flush_cnt      out  CNT_W  accepted redirects, saturating
// BEHAVIOUR
//  Reset (RST=0 at posedge): state=RUN, flush counter=0, stall_cnt=0, flush_cnt=0.
//  While RST=0, outputs are forced combinationally: all *_en=0, ifid_flush=1, idex_flush=1.
//  Outputs are combinational from the registered state and current inputs; zero-cycle response.
//  load_use = ex_mem_to_reg & ex_WRegEn & (ex_WReg1!=0) & ((id_use_rs1 & id_rs1==ex_WReg1) | (id_use_rs2 & id_rs2==ex_WReg1)).
//  Priority per cycle: mem_busy > ex_redirect > load_use > normal.
//  mem_busy=1 (any state):
//    - all *_en=0, both flushes=0.
//    - Enter/stay MWAIT; RUN/FLUSH and the remaining flush count are saved.
//    - ex_redirect is ignored; it is resampled after release, since EX is frozen.
//  MWAIT with mem_busy=0: return to saved state and evaluate that state's rules in the same cycle.
//  RUN:
//    - ex_redirect: all en=1, ifid_flush=1, idex_flush=1, flush_cnt++.
//      If FLUSH_CYCLES>1, load remaining count with FLUSH_CYCLES-1 and go to FLUSH; else stay in RUN.
//    - else load_use: pc_en=0, ifid_en=0, idex_en=1, exmem_en=1, idex_flush=1 (one bubble).
//      Stay in RUN; the hazard clears the next cycle once the load advances.
//    - else: all en=1, flushes=0.
//  FLUSH:
//    - all en=1, ifid_flush=1, idex_flush=1; load_use is ignored (ID is being squashed).
//    - Decrement the remaining count; go to RUN when it reaches 0.
//    - A new ex_redirect reloads FLUSH_CYCLES-1 and does flush_cnt++.
//  stall_cnt++ each cycle with pc_en=0 while RST=1. Both counters hold at all-ones.
//  clr_cnt zeroes both counters and beats a same-cycle increment.
//  Reset asserted mid-FLUSH or mid-MWAIT discards the saved state and returns to RUN.
// TESTING
//  1. EX holds a load: WReg1=5, WRegEn=1, mem_to_reg=1. ID has rs2=5, use_rs2=1.
//     -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
//  2. Same as 1 but WReg1=0, or use_rs2=0 -> no stall; all en=1, stall_cnt=0.
//  3. FLUSH_CYCLES=3, ex_redirect pulse -> ifid_flush=1 for exactly 3 cycles.
//     state_out 0,1,1,0; flush_cnt=1; load_use during those cycles is ignored.
//  4. mem_busy=1 for 4 cycles in the 2nd flush cycle, redirect held high throughout.
//     -> all en=0 and state_out=2 for 4 cycles; then FLUSH resumes with 1 cycle left.
//     flush_cnt=1, stall_cnt=4.
//  5. CNT_W=4, hold mem_busy for 20 cycles -> stall_cnt stops at 15.
//     clr_cnt pulse while mem_busy=1 -> stall_cnt=0 that cycle, then counts again.
//  6. RST=0 during FLUSH -> next cycle state_out=0, counters 0.
//     While RST=0: en=0, flushes=1. After release, first cycle is normal RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stall enables, flush strobes, load-use
// detection, redirect squashing, memory-busy freeze and saturating statistics.
//
// state | meaning
// RUN   | normal issue; redirects flush, load-use inserts one bubble
// FLUSH | squashing wrong-path fetches for the remaining flush count
// MWAIT | data memory busy; whole pipe frozen, RUN/FLUSH context saved
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_to_reg,
    input  logic             ex_WRegEn,
    input  logic [4:0]       ex_WReg1,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        MWAIT = 2'd2
    } state_t;

    localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    state_t     saved, saved_nxt;
    state_t     act;
    logic [3:0] rem, rem_nxt;
    logic       load_use;
    logic       flush_inc;
    logic       stall_inc;

    assign load_use = ex_mem_to_reg & ex_WRegEn & (ex_WReg1 != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_WReg1)) |
                       (id_use_rs2 & (id_rs2 == ex_WReg1)));

    always_comb begin
        state_nxt  = state;
        saved_nxt  = saved;
        rem_nxt    = rem;
        flush_inc  = 1'b0;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        // On release from MWAIT the saved context acts in the same cycle.
        act        = (state == MWAIT) ? saved : state;
        state_out  = act;

        if (!RST) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_out  = RUN;
        end else if (mem_busy) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            state_nxt = MWAIT;
            state_out = MWAIT;
            if (state != MWAIT) saved_nxt = state;
        end else begin
            state_nxt = act;
            case (act)
                FLUSH: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (ex_redirect) begin
                        rem_nxt   = RELOAD;
                        flush_inc = 1'b1;
                    end else begin
                        rem_nxt = rem - 4'd1;
                        if (rem == 4'd1) state_nxt = RUN;
                    end
                end
                default: begin
                    if (ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            rem_nxt   = RELOAD;
                            state_nxt = FLUSH;
                        end
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    assign stall_inc = ~pc_en;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= RUN;
            saved     <= RUN;
            rem       <= 4'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            saved <= saved_nxt;
            rem   <= rem_nxt;
            if (clr_cnt) begin
                stall_cnt <= '0;
                flush_cnt <= '0;
            end else begin
                if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
                if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (FLUSH_CYCLES=3/CNT_W=4 and
// FLUSH_CYCLES=1/CNT_W=16) checked against a squash-count reference model.
module tb_pipe_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] id_rs1, id_rs2, ex_WReg1;
    logic       id_use_rs1, id_use_rs2, ex_mem_to_reg, ex_WRegEn;
    logic       ex_redirect, mem_busy, clr_cnt;

    logic        a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_ifid_flush, a_idex_flush;
    logic [1:0]  a_state_out;
    logic [3:0]  a_stall_cnt, a_flush_cnt;
    logic        b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_ifid_flush, b_idex_flush;
    logic [1:0]  b_state_out;
    logic [15:0] b_stall_cnt, b_flush_cnt;
    logic [7:0]  a_ctl, b_ctl;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per instance, squash cycles still owed and counter values.
    int          fc[2]   = '{3, 1};
    logic [31:0] maxc[2] = '{32'd15, 32'd65535};
    int          m_left[2];
    logic [31:0] m_stall[2], m_flush[2];
    int          n_left[2];
    logic [31:0] n_stall[2], n_flush[2];
    logic [7:0]  e_ctl[2];

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_a (
        .CLK(CLK), .RST(RST), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_WRegEn(ex_WRegEn), .ex_WReg1(ex_WReg1),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .pc_en(a_pc_en), .ifid_en(a_ifid_en), .idex_en(a_idex_en), .exmem_en(a_exmem_en),
        .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .state_out(a_state_out),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_b (
        .CLK(CLK), .RST(RST), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_WRegEn(ex_WRegEn), .ex_WReg1(ex_WReg1),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en), .exmem_en(b_exmem_en),
        .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .state_out(b_state_out),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    assign a_ctl = {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_ifid_flush, a_idex_flush, a_state_out};
    assign b_ctl = {b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_ifid_flush, b_idex_flush, b_state_out};

    task automatic eval_model;
        logic lu, st_inc, fl_inc;
        for (int k = 0; k < 2; k++) begin
            lu = ex_mem_to_reg && ex_WRegEn && (ex_WReg1 != 0) &&
                 ((id_use_rs1 && id_rs1 == ex_WReg1) || (id_use_rs2 && id_rs2 == ex_WReg1));
            st_inc = 0;
            fl_inc = 0;
            n_left[k] = m_left[k];
            if (!RST) begin
                e_ctl[k]  = 8'b0000_11_00;
                n_left[k] = 0;
            end else if (mem_busy) begin
                e_ctl[k] = 8'b0000_00_10;
                st_inc   = 1;
            end else if (m_left[k] > 0) begin
                e_ctl[k] = 8'b1111_11_01;
                if (ex_redirect) begin
                    n_left[k] = fc[k] - 1;
                    fl_inc    = 1;
                end else begin
                    n_left[k] = m_left[k] - 1;
                end
            end else if (ex_redirect) begin
                e_ctl[k]  = 8'b1111_11_00;
                n_left[k] = fc[k] - 1;
                fl_inc    = 1;
            end else if (lu) begin
                e_ctl[k] = 8'b0011_01_00;
                st_inc   = 1;
            end else begin
                e_ctl[k] = 8'b1111_00_00;
            end
            if (!RST || clr_cnt) begin
                n_stall[k] = 0;
                n_flush[k] = 0;
            end else begin
                n_stall[k] = (st_inc && m_stall[k] < maxc[k]) ? m_stall[k] + 1 : m_stall[k];
                n_flush[k] = (fl_inc && m_flush[k] < maxc[k]) ? m_flush[k] + 1 : m_flush[k];
            end
        end
    endtask

    task automatic settle;
        #1;
        eval_model();
    endtask

    task automatic tick;
        @(posedge CLK);
        for (int k = 0; k < 2; k++) begin
            m_left[k]  = n_left[k];
            m_stall[k] = n_stall[k];
            m_flush[k] = n_flush[k];
        end
        @(negedge CLK);
    endtask

    task automatic set_idle;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_mem_to_reg = 0; ex_WRegEn = 0; ex_WReg1 = 0;
        ex_redirect = 0; mem_busy = 0; clr_cnt = 0;
    endtask

    task automatic set_load_hazard;
        ex_mem_to_reg = 1; ex_WRegEn = 1; ex_WReg1 = 5;
        id_rs2 = 5; id_use_rs2 = 1; id_rs1 = 7; id_use_rs1 = 1;
    endtask

    task automatic clear_counters;
        set_idle();
        clr_cnt = 1;
        settle();
        tick();
        clr_cnt = 0;
    endtask

    task automatic test_reset;
        set_idle();
        RST = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_tests++;
            if (a_ctl !== 8'b0000_11_00) begin
                n_fail++;
                $display("FAIL reset_ctl: got %b want %b", a_ctl, 8'b0000_11_00);
            end
            tick();
        end
        RST = 1;
        settle();
        n_tests++;
        if (a_ctl !== 8'b1111_00_00 || b_ctl !== 8'b1111_00_00) begin
            n_fail++;
            $display("FAIL reset_release_ctl: got a=%b b=%b want 11110000", a_ctl, b_ctl);
        end
        n_tests++;
        if (a_stall_cnt !== 4'd0 || a_flush_cnt !== 4'd0 || b_stall_cnt !== 16'd0 || b_flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d %0d %0d %0d want 0", a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt);
        end
        tick();
    endtask

    task automatic test_load_use;
        clear_counters();
        set_load_hazard();
        settle();
        n_tests++;
        if (a_ctl !== 8'b0011_01_00 || b_ctl !== e_ctl[1]) begin
            n_fail++;
            $display("FAIL load_use_ctl: got a=%b b=%b want 00110100", a_ctl, b_ctl);
        end
        tick();
        set_idle();
        settle();
        n_tests++;
        if (a_stall_cnt !== 4'd1 || a_ctl !== 8'b1111_00_00) begin
            n_fail++;
            $display("FAIL load_use_after: got stall=%0d ctl=%b want 1 11110000", a_stall_cnt, a_ctl);
        end
        tick();
        // rs1 path
        set_load_hazard();
        id_use_rs2 = 0; id_rs1 = 5;
        settle();
        n_tests++;
        if (a_ctl !== e_ctl[0]) begin
            n_fail++;
            $display("FAIL load_use_rs1: got %b want %b", a_ctl, e_ctl[0]);
        end
        tick();
        clear_counters();
        // x0 destination and unused operand must not stall
        set_load_hazard();
        ex_WReg1 = 0; id_rs2 = 0;
        settle();
        n_tests++;
        if (a_ctl !== 8'b1111_00_00) begin
            n_fail++;
            $display("FAIL load_use_x0: got %b want 11110000", a_ctl);
        end
        tick();
        set_load_hazard();
        id_use_rs2 = 0;
        settle();
        n_tests++;
        if (a_ctl !== 8'b1111_00_00) begin
            n_fail++;
            $display("FAIL load_use_nouse: got %b want 11110000", a_ctl);
        end
        tick();
        set_idle();
        settle();
        n_tests++;
        if (a_stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL load_use_nostall_cnt: got %0d want 0", a_stall_cnt);
        end
        tick();
    endtask

    task automatic test_redirect_flush;
        logic [7:0] exp_a[4] = '{8'b1111_11_00, 8'b1111_11_01, 8'b1111_11_01, 8'b0011_01_00};
        clear_counters();
        for (int c = 0; c < 4; c++) begin
            set_idle();
            if (c == 0) ex_redirect = 1;
            else set_load_hazard();
            settle();
            n_tests++;
            if (a_ctl !== exp_a[c] || b_ctl !== e_ctl[1]) begin
                n_fail++;
                $display("FAIL redirect_seq[%0d]: got a=%b b=%b want a=%b b=%b", c, a_ctl, b_ctl, exp_a[c], e_ctl[1]);
            end
            tick();
        end
        set_idle();
        settle();
        n_tests++;
        if (a_flush_cnt !== 4'd1 || b_flush_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL redirect_flush_cnt: got a=%0d b=%0d want 1", a_flush_cnt, b_flush_cnt);
        end
        tick();
    endtask

    task automatic test_busy_freeze;
        clear_counters();
        set_idle();
        ex_redirect = 1;
        settle();
        tick();
        ex_redirect = 0;
        settle();
        n_tests++;
        if (a_ctl !== 8'b1111_11_01) begin
            n_fail++;
            $display("FAIL busy_first_flush: got %b want 11110101", a_ctl);
        end
        tick();
        for (int c = 0; c < 4; c++) begin
            mem_busy = 1; ex_redirect = 1;
            settle();
            n_tests++;
            if (a_ctl !== 8'b0000_00_10 || b_ctl !== 8'b0000_00_10) begin
                n_fail++;
                $display("FAIL busy_frozen[%0d]: got a=%b b=%b want 00000010", c, a_ctl, b_ctl);
            end
            tick();
        end
        set_idle();
        settle();
        n_tests++;
        if (a_ctl !== 8'b1111_11_01 || b_ctl !== 8'b1111_00_00) begin
            n_fail++;
            $display("FAIL busy_resume: got a=%b b=%b want a=11110101 b=11110000", a_ctl, b_ctl);
        end
        tick();
        settle();
        n_tests++;
        if (a_ctl !== 8'b1111_00_00) begin
            n_fail++;
            $display("FAIL busy_back_to_run: got %b want 11110000", a_ctl);
        end
        n_tests++;
        if (a_flush_cnt !== 4'd1 || a_stall_cnt !== 4'd4 || b_flush_cnt !== 16'd1 || b_stall_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL busy_counters: got a=%0d/%0d b=%0d/%0d want 1/4", a_flush_cnt, a_stall_cnt, b_flush_cnt, b_stall_cnt);
        end
        tick();
    endtask

    task automatic test_saturation;
        clear_counters();
        set_idle();
        mem_busy = 1;
        for (int c = 0; c < 20; c++) begin
            settle();
            tick();
        end
        settle();
        n_tests++;
        if (a_stall_cnt !== 4'd15 || b_stall_cnt !== 16'd20) begin
            n_fail++;
            $display("FAIL sat_stall: got a=%0d b=%0d want a=15 b=20", a_stall_cnt, b_stall_cnt);
        end
        clr_cnt = 1;
        settle();
        tick();
        clr_cnt = 0;
        settle();
        n_tests++;
        if (a_stall_cnt !== 4'd0 || b_stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL sat_clear: got a=%0d b=%0d want 0", a_stall_cnt, b_stall_cnt);
        end
        tick();
        settle();
        n_tests++;
        if (a_stall_cnt !== 4'd1 || 32'(b_stall_cnt) !== m_stall[1]) begin
            n_fail++;
            $display("FAIL sat_recount: got a=%0d b=%0d want 1", a_stall_cnt, b_stall_cnt);
        end
        tick();
        set_idle();
        settle();
        tick();
    endtask

    task automatic test_reset_mid;
        set_idle();
        ex_redirect = 1;
        settle();
        tick();
        set_idle();
        settle();
        n_tests++;
        if (a_state_out !== 2'd1) begin
            n_fail++;
            $display("FAIL midrst_in_flush: got state=%0d want 1", a_state_out);
        end
        RST = 0;
        settle();
        n_tests++;
        if (a_ctl !== 8'b0000_11_00) begin
            n_fail++;
            $display("FAIL midrst_forced: got %b want 00001100", a_ctl);
        end
        tick();
        RST = 1;
        settle();
        n_tests++;
        if (a_ctl !== 8'b1111_00_00 || a_flush_cnt !== 4'd0 || a_stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL midrst_release: got ctl=%b flush=%0d stall=%0d want 11110000 0 0", a_ctl, a_flush_cnt, a_stall_cnt);
        end
        tick();
        // reset while frozen inside FLUSH context
        ex_redirect = 1;
        settle();
        tick();
        ex_redirect = 0; mem_busy = 1;
        settle();
        tick();
        RST = 0;
        settle();
        tick();
        RST = 1; mem_busy = 0;
        settle();
        n_tests++;
        if (a_ctl !== 8'b1111_00_00) begin
            n_fail++;
            $display("FAIL midrst_mwait: got %b want 11110000", a_ctl);
        end
        tick();
    endtask

    task automatic test_random;
        for (int c = 0; c < 500; c++) begin
            RST           = ($urandom_range(0, 63) != 0);
            clr_cnt       = ($urandom_range(0, 31) == 0);
            mem_busy      = ($urandom_range(0, 3) == 0);
            ex_redirect   = ($urandom_range(0, 5) == 0);
            ex_mem_to_reg = $urandom_range(0, 1);
            ex_WRegEn     = ($urandom_range(0, 3) != 0);
            ex_WReg1      = 5'($urandom_range(0, 3));
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_use_rs1    = $urandom_range(0, 1);
            id_use_rs2    = $urandom_range(0, 1);
            settle();
            n_tests++;
            if (a_ctl !== e_ctl[0] || b_ctl !== e_ctl[1]) begin
                n_fail++;
                $display("FAIL rand_ctl[%0d]: got a=%b b=%b want a=%b b=%b", c, a_ctl, b_ctl, e_ctl[0], e_ctl[1]);
            end
            n_tests++;
            if (32'(a_stall_cnt) !== m_stall[0] || 32'(a_flush_cnt) !== m_flush[0] ||
                32'(b_stall_cnt) !== m_stall[1] || 32'(b_flush_cnt) !== m_flush[1]) begin
                n_fail++;
                $display("FAIL rand_cnt[%0d]: got a=%0d/%0d b=%0d/%0d want a=%0d/%0d b=%0d/%0d", c,
                         a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt,
                         m_stall[0], m_flush[0], m_stall[1], m_flush[1]);
            end
            tick();
        end
        RST = 1;
        set_idle();
    endtask

    initial begin
        RST = 0;
        set_idle();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end
        @(negedge CLK);
        test_reset();
        test_load_use();
        test_redirect_flush();
        test_busy_freeze();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
